palette_ram: RTL and testbench

- Writable, parametrised colour palette for the VGA path: maps a colour index to a COLOR_W-bit RGB value.
- Two independent registered read ports: port A for the sprite layer, port B for the background layer.
- One write port with valid/ready handshake, so software or the game FSM can recolour entries at run time.
- After reset, an init sequencer reloads the default palette, one entry per cycle.

---
 rtl/palette_ram.sv | 182 ++++++++++++++++++
 tb/tb_palette_ram.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_ram.sv
// palette_ram: writable colour palette with two registered read ports, a valid/ready
// write port and a post-reset default loader. Define PALETTE_FADE_EN to add a fade stage.
module palette_ram #(
   parameter int IDX_W       = 4,
   parameter int NUM_ENTRIES = 16,
   parameter int COLOR_W     = 24
) (
   input  logic               Clk,
   input  logic               Reset,
`ifdef PALETTE_FADE_EN
   input  logic [3:0]         fade,
`endif
   input  logic [IDX_W-1:0]   rd_addr_a,
   output logic [COLOR_W-1:0] rd_data_a,
   input  logic [IDX_W-1:0]   rd_addr_b,
   output logic [COLOR_W-1:0] rd_data_b,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [IDX_W-1:0]   wr_addr,
   input  logic [COLOR_W-1:0] wr_data,
   output logic               wr_err,
   output logic               init_done
);

   localparam int CH_W = COLOR_W / 3;
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [IDX_W:0]   NUM_E    = (IDX_W+1)'(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

   logic [COLOR_W-1:0] mem_q [NUM_ENTRIES];

   logic [0:0]         state_q, state_d;
   logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;
   logic               wr_err_q, wr_err_d;
   logic [COLOR_W-1:0] rd_a_p1_q, rd_a_p1_d;
   logic [COLOR_W-1:0] rd_b_p1_q, rd_b_p1_d;
   logic               mem_we;
   logic [IDX_W-1:0]   mem_waddr;
   logic [COLOR_W-1:0] mem_wdata;
   logic               wr_fire;

   function automatic logic in_range(input logic [IDX_W-1:0] a);
      return {1'b0, a} < NUM_E;
   endfunction

   // Defaults are 8-bit-per-channel; each channel is MSB-aligned into CH_W bits.
   function automatic logic [COLOR_W-1:0] default_color(input logic [IDX_W-1:0] idx);
      logic [23:0]        raw;
      logic [COLOR_W-1:0] res;
      int                 src;
      case (32'(idx))
         0:       raw = 24'hFF00FF;
         1:       raw = 24'h000000;
         2:       raw = 24'hFFFFFF;
         3:       raw = 24'h313129;
         4:       raw = 24'h5A5A52;
         5:       raw = 24'h848C73;
         6:       raw = 24'h840000;
         7:       raw = 24'hFF0000;
         8:       raw = 24'h848400;
         9:       raw = 24'hFFFF00;
         10:      raw = 24'hA5AD94;
         11:      raw = 24'h0084FF;
         12:      raw = 24'h0042BD;
         default: raw = 24'h000000;
      endcase
      res = '0;
      for (int ch = 0; ch < 3; ch++) begin
         for (int b = 0; b < CH_W; b++) begin
            src = b + 8 - CH_W;
            if (src >= 0) res[ch*CH_W + b] = raw[ch*8 + src];
         end
      end
      return res;
   endfunction

`ifdef PALETTE_FADE_EN
   function automatic logic [COLOR_W-1:0] fade_color(input logic [COLOR_W-1:0] c,
                                                     input logic [3:0] f);
      logic [COLOR_W-1:0] res;
      logic [CH_W+3:0]    prod;
      for (int ch = 0; ch < 3; ch++) begin
         prod = (CH_W+4)'(c[ch*CH_W +: CH_W]) * (CH_W+4)'({1'b0, f} + 5'd1);
         res[ch*CH_W +: CH_W] = CH_W'(prod >> 4);
      end
      return res;
   endfunction
`endif

   assign wr_fire = (state_q == ST_RUN) && wr_valid;

   // Stage p1: FSM, memory write select and registered reads with write-first bypass
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      wr_err_d   = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = init_cnt_q;
      mem_wdata  = default_color(init_cnt_q);
      rd_a_p1_d  = '0;
      rd_b_p1_d  = '0;
      case (state_q)
         ST_INIT: begin
            mem_we     = 1'b1;
            init_cnt_d = init_cnt_q + IDX_W'(1);
            if (init_cnt_q == LAST_IDX) state_d = ST_RUN;
         end
         default: begin
            if (wr_fire) begin
               if (in_range(wr_addr)) begin
                  mem_we    = 1'b1;
                  mem_waddr = wr_addr;
                  mem_wdata = wr_data;
               end else begin
                  wr_err_d = 1'b1;
               end
            end
            if (in_range(rd_addr_a)) rd_a_p1_d = mem_q[rd_addr_a];
            if (in_range(rd_addr_b)) rd_b_p1_d = mem_q[rd_addr_b];
            if (mem_we && (wr_addr == rd_addr_a)) rd_a_p1_d = wr_data;
            if (mem_we && (wr_addr == rd_addr_b)) rd_b_p1_d = wr_data;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
         wr_err_q   <= 1'b0;
         rd_a_p1_q  <= '0;
         rd_b_p1_q  <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wr_err_q   <= wr_err_d;
         rd_a_p1_q  <= rd_a_p1_d;
         rd_b_p1_q  <= rd_b_p1_d;
      end
   end

   // Storage is not reset; the INIT sequencer rewrites every entry.
   always_ff @(posedge Clk) begin
      if (!Reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

`ifdef PALETTE_FADE_EN
   // Stage p2: fade scaling, with fade sampled alongside the read address
   logic [3:0]         fade_p1_q;
   logic [COLOR_W-1:0] rd_a_p2_q, rd_a_p2_d;
   logic [COLOR_W-1:0] rd_b_p2_q, rd_b_p2_d;

   always_comb begin
      rd_a_p2_d = fade_color(rd_a_p1_q, fade_p1_q);
      rd_b_p2_d = fade_color(rd_b_p1_q, fade_p1_q);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         fade_p1_q <= '0;
         rd_a_p2_q <= '0;
         rd_b_p2_q <= '0;
      end else begin
         fade_p1_q <= fade;
         rd_a_p2_q <= rd_a_p2_d;
         rd_b_p2_q <= rd_b_p2_d;
      end
   end

   assign rd_data_a = rd_a_p2_q;
   assign rd_data_b = rd_b_p2_q;
`else
   assign rd_data_a = rd_a_p1_q;
   assign rd_data_b = rd_b_p1_q;
`endif

   assign wr_ready  = (state_q == ST_RUN);
   assign init_done = (state_q == ST_RUN);
   assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_palette_ram.sv
// Scoreboard bench for palette_ram: a 16-entry and a 13-entry instance share stimulus;
// expected colours are queued at drive time and compared when the read latency elapses.
module tb_palette_ram;

`ifdef PALETTE_FADE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic [3:0]  ra, rb, wa;
   logic        wv;
   logic [23:0] wd;
   logic [3:0]  fade_tb;

   logic [23:0] da, db, da13, db13;
   logic        wready, werr, idone;
   logic        wready13, werr13, idone13;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          due;
      logic [23:0] a, b, a13, b13;
   } rd_item_t;

   typedef struct {
      int   due;
      logic e16, e13;
   } err_item_t;

   rd_item_t  rd_q[$];
   err_item_t err_q[$];

   logic [23:0] model   [16];
   logic [23:0] model13 [16];

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   palette_ram #(.IDX_W(4), .NUM_ENTRIES(16), .COLOR_W(24)) dut (
      .Clk(Clk), .Reset(Reset),
`ifdef PALETTE_FADE_EN
      .fade(fade_tb),
`endif
      .rd_addr_a(ra), .rd_data_a(da), .rd_addr_b(rb), .rd_data_b(db),
      .wr_valid(wv), .wr_ready(wready), .wr_addr(wa), .wr_data(wd),
      .wr_err(werr), .init_done(idone)
   );

   palette_ram #(.IDX_W(4), .NUM_ENTRIES(13), .COLOR_W(24)) dut13 (
      .Clk(Clk), .Reset(Reset),
`ifdef PALETTE_FADE_EN
      .fade(fade_tb),
`endif
      .rd_addr_a(ra), .rd_data_a(da13), .rd_addr_b(rb), .rd_data_b(db13),
      .wr_valid(wv), .wr_ready(wready13), .wr_addr(wa), .wr_data(wd),
      .wr_err(werr13), .init_done(idone13)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] dflt(input int i);
      case (i)
         0:       return 24'hFF00FF;
         1:       return 24'h000000;
         2:       return 24'hFFFFFF;
         3:       return 24'h313129;
         4:       return 24'h5A5A52;
         5:       return 24'h848C73;
         6:       return 24'h840000;
         7:       return 24'hFF0000;
         8:       return 24'h848400;
         9:       return 24'hFFFF00;
         10:      return 24'hA5AD94;
         11:      return 24'h0084FF;
         12:      return 24'h0042BD;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic logic [23:0] fadef(input logic [23:0] c);
      logic [23:0] r;
      int          v;
      for (int k = 0; k < 3; k++) begin
         v = int'(c[k*8 +: 8]) * (int'(fade_tb) + 1);
         r[k*8 +: 8] = 8'(v >> 4);
      end
      return r;
   endfunction

   task automatic load_defaults();
      for (int i = 0; i < 16; i++) begin
         model[i]   = dflt(i);
         model13[i] = (i < 13) ? dflt(i) : 24'h0;
      end
   endtask

   // One stimulus cycle: drive inputs, update the model, queue the expectations.
   task automatic step(input logic [3:0] a, input logic [3:0] b, input logic v,
                       input logic [3:0] w_a, input logic [23:0] w_d);
      rd_item_t  it;
      err_item_t ei;
      @(negedge Clk);
      ra = a; rb = b; wv = v; wa = w_a; wd = w_d;
      if (v) begin
         model[w_a] = w_d;
         if (w_a < 4'd13) model13[w_a] = w_d;
      end
      it.due = cyc + LAT;
      it.a   = fadef(model[a]);
      it.b   = fadef(model[b]);
      it.a13 = (a < 4'd13) ? fadef(model13[a]) : 24'h0;
      it.b13 = (b < 4'd13) ? fadef(model13[b]) : 24'h0;
      rd_q.push_back(it);
      ei.due = cyc + 1;
      ei.e16 = 1'b0;
      ei.e13 = v && (w_a >= 4'd13);
      err_q.push_back(ei);
   endtask

   task automatic drain();
      int n;
      @(negedge Clk);
      wv = 1'b0;
      n = 0;
      while ((rd_q.size() > 0 || err_q.size() > 0) && n < 10) begin
         @(negedge Clk);
         n++;
      end
      if (rd_q.size() > 0 || err_q.size() > 0) check_eq("drain", 32'(rd_q.size() + err_q.size()), 32'd0);
   endtask

   task automatic wait_init(output int n, output int n13);
      n = 0;
      n13 = -1;
      while (!idone && n < 40) begin
         @(posedge Clk);
         n++;
         @(negedge Clk);
         if (idone13 && n13 < 0) n13 = n;
         if (!idone) check_eq("init_rd_a", 32'(da), 32'd0);
      end
   endtask

   always @(negedge Clk) begin : mon
      rd_item_t  it;
      err_item_t ei;
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
         it = rd_q.pop_front();
         check_eq("rd_a",   32'(da),   32'(it.a));
         check_eq("rd_b",   32'(db),   32'(it.b));
         check_eq("rd_a13", 32'(da13), 32'(it.a13));
         check_eq("rd_b13", 32'(db13), 32'(it.b13));
      end
      if (err_q.size() > 0 && err_q[0].due == cyc) begin
         ei = err_q.pop_front();
         check_eq("wr_err",   32'(werr),   32'(ei.e16));
         check_eq("wr_err13", 32'(werr13), 32'(ei.e13));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n13;
      Reset = 1'b1; ra = 4'd2; rb = 4'd0; wv = 1'b0; wa = '0; wd = '0; fade_tb = 4'd15;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check_eq("rst_rd_a", 32'(da), 32'd0);
      check_eq("rst_rd_b", 32'(db), 32'd0);
      check_eq("rst_wr_ready", 32'(wready), 32'd0);
      check_eq("rst_wr_err", 32'(werr), 32'd0);
      check_eq("rst_init_done", 32'(idone), 32'd0);

      Reset = 1'b0;
      wait_init(n, n13);
      check_eq("init_latency", 32'(n), 32'd16);
      check_eq("init13_latency", 32'(n13), 32'd13);
      check_eq("run_wr_ready", 32'(wready), 32'd1);
      repeat (LAT) @(posedge Clk);
      @(negedge Clk);
      check_eq("first_read", 32'(da), 32'h00FFFFFF);

      load_defaults();
      // Write then read back, plus untouched neighbour
      step(4'd0, 4'd1, 1'b1, 4'd3, 24'h123456);
      step(4'd3, 4'd4, 1'b0, 4'd0, 24'h0);
      // Same-cycle write and read: bypass on port B
      step(4'd2, 4'd7, 1'b1, 4'd7, 24'h00FF00);
      step(4'd7, 4'd7, 1'b0, 4'd0, 24'h0);
      // Index 14: in range for 16 entries, out of range for 13
      step(4'd14, 4'd13, 1'b1, 4'd14, 24'hABCDEF);
      step(4'd14, 4'd15, 1'b0, 4'd0, 24'h0);
      step(4'd12, 4'd14, 1'b1, 4'd15, 24'h00000F);
      for (int i = 0; i < 40; i++)
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 24'($urandom));
      drain();

      // Reset during RUN discards run-time writes and drops the reset-cycle write
      step(4'd0, 4'd0, 1'b1, 4'd0, 24'hABCDEF);
      step(4'd0, 4'd1, 1'b0, 4'd0, 24'h0);
      drain();
      @(negedge Clk);
      Reset = 1'b1; wv = 1'b1; wa = 4'd1; wd = 24'h111111;
      @(posedge Clk);
      @(negedge Clk);
      check_eq("mid_rst_init_done", 32'(idone), 32'd0);
      check_eq("mid_rst_wr_ready", 32'(wready), 32'd0);
      check_eq("mid_rst_rd_a", 32'(da), 32'd0);
      Reset = 1'b0; wv = 1'b0; ra = 4'd0;
      wait_init(n, n13);
      check_eq("reinit_latency", 32'(n), 32'd16);
      load_defaults();
      step(4'd0, 4'd1, 1'b0, 4'd0, 24'h0);
      step(4'd7, 4'd3, 1'b0, 4'd0, 24'h0);
      drain();

`ifdef PALETTE_FADE_EN
      fade_tb = 4'd7;
      step(4'd7, 4'd2, 1'b0, 4'd0, 24'h0);
      drain();
      fade_tb = 4'd15;
      step(4'd7, 4'd2, 1'b0, 4'd0, 24'h0);
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
